// File: rtl/jesd_pattern_pkg.sv
// Shared definitions for the JESD loopback test-pattern generator and its RX checker.
package jesd_pattern_pkg;

  // Pattern select encodings, as driven on MODE.
  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_CONST  = 2'd2,
    MODE_WALK1  = 2'd3
  } mode_e;

  // Generator control states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StBlank = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned PRBS_W = 15;

  // x^15 + x^14 + 1: feedback from state bits 14 and 13.
  localparam logic [PRBS_W-1:0] PRBS15_TAPS = 15'h6000;

  // Lane i is seeded with SEED_BASE ^ i so lanes are decorrelated.
  localparam logic [PRBS_W-1:0] SEED_BASE = 15'h7FFF;

  // Lane i in CONST mode repeats byte CONST_BASE + i.
  localparam logic [7:0] CONST_BASE = 8'hA0;

endpackage

// File: rtl/prbs15_lane.sv
// One lane of PRBS15: advances the LFSR DATA_W bits in a single combinational step.
module prbs15_lane
  import jesd_pattern_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [PRBS_W-1:0] state,
  output logic [PRBS_W-1:0] next_state,
  output logic [DATA_W-1:0] data
);

  // Unrolled Fibonacci LFSR; the first generated bit lands in the word MSB.
  always_comb begin
    logic [PRBS_W-1:0] s;
    logic              fb;
    s    = state;
    data = '0;
    for (int k = 0; k < DATA_W; k++) begin
      fb                 = ^(s & PRBS15_TAPS);
      data[DATA_W-1-k]   = fb;
      s                  = {s[PRBS_W-2:0], fb};
    end
    next_state = s;
  end

endmodule

// File: rtl/jesd_pattern_gen.sv
// Multi-lane test-pattern source (COUNT / PRBS15 / CONST / WALK1) with burst length,
// READY back-pressure and TRIG blanking. All outputs are registered.
module jesd_pattern_gen
  import jesd_pattern_pkg::*;
#(
  parameter int unsigned       LANES     = 2,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MARK_W    = 4,
  parameter logic [MARK_W-1:0] MARKER    = 4'b1010,
  // Must equal DATA_W - MARK_W.
  parameter int unsigned       CNT_W     = 28,
  // 0 means run continuously.
  parameter int unsigned       BURST_LEN = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    TRIG,
  input  logic [1:0]              MODE,
  input  logic                    READY,
  output logic [LANES*DATA_W-1:0] DATA,
  output logic                    DATA_VALID,
  output logic                    WRAP,
  output logic                    BURST_DONE
);

  state_e             state_q;
  mode_e              mode_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        beat_q;
  logic               trig_r;

  // lfsr_q is the LFSR state after the presented PRBS word; prbs_q is that word, kept so
  // a blanked beat can be re-presented unchanged.
  logic [PRBS_W-1:0]  lfsr_q     [LANES];
  logic [DATA_W-1:0]  prbs_q     [LANES];
  logic [PRBS_W-1:0]  step_in    [LANES];
  logic [PRBS_W-1:0]  step_state [LANES];
  logic [DATA_W-1:0]  step_data  [LANES];

  logic               accept;
  logic               burst_end;
  mode_e              mode_sel;
  logic [CNT_W-1:0]   count_sel;
  logic [DATA_W-1:0]  prbs_sel   [LANES];
  logic [LANES*DATA_W-1:0] pat;
  logic               wrap_hit;

  // In IDLE the step engine runs from the seeds so the first PRBS word is ready at start.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign step_in[g] = (state_q == StIdle) ? (SEED_BASE ^ PRBS_W'(g)) : lfsr_q[g];

    prbs15_lane #(
      .DATA_W (DATA_W)
    ) u_prbs (
      .state      (step_in[g]),
      .next_state (step_state[g]),
      .data       (step_data[g])
    );
  end

  // Blank beats never count, so only RUN can accept.
  assign accept    = (state_q == StRun) && READY;
  assign burst_end = (BURST_LEN != 0) && accept && (beat_q == BURST_LEN - 1);

  // Select the mode/count/PRBS word of the beat to present next, then build lane words.
  always_comb begin
    mode_sel  = mode_q;
    count_sel = count_q;
    for (int i = 0; i < LANES; i++) prbs_sel[i] = prbs_q[i];
    unique case (state_q)
      StIdle: begin
        mode_sel  = mode_e'(MODE);
        count_sel = '0;
        for (int i = 0; i < LANES; i++) prbs_sel[i] = step_data[i];
      end
      StRun: begin
        if (accept) begin
          count_sel = count_q + CNT_W'(1);
          for (int i = 0; i < LANES; i++) prbs_sel[i] = step_data[i];
        end
      end
      default: ;
    endcase

    pat = '0;
    for (int i = 0; i < LANES; i++) begin
      unique case (mode_sel)
        MODE_COUNT:  pat[i*DATA_W +: DATA_W] = {count_sel + CNT_W'(i), MARKER};
        MODE_PRBS15: pat[i*DATA_W +: DATA_W] = prbs_sel[i];
        MODE_CONST:  pat[i*DATA_W +: DATA_W] = {(DATA_W/8){CONST_BASE + 8'(i)}};
        MODE_WALK1:  pat[i*DATA_W +: DATA_W] = DATA_W'(1) << (32'(count_sel) % DATA_W);
        default:     pat[i*DATA_W +: DATA_W] = '0;
      endcase
    end

    // Only a newly presented max-count beat flags WRAP, not one held by READY=0.
    wrap_hit = (count_sel == '1) &&
               ((mode_sel == MODE_COUNT) || (mode_sel == MODE_WALK1)) &&
               ((state_q != StRun) || accept);
  end

  // Control FSM with registered outputs; priority is EN=0, then burst end, then trig_r.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      mode_q     <= MODE_COUNT;
      count_q    <= '0;
      beat_q     <= '0;
      trig_r     <= 1'b0;
      DATA       <= '0;
      DATA_VALID <= 1'b0;
      WRAP       <= 1'b0;
      BURST_DONE <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lfsr_q[i] <= SEED_BASE ^ PRBS_W'(i);
        prbs_q[i] <= '0;
      end
    end else begin
      trig_r     <= TRIG;
      WRAP       <= 1'b0;
      BURST_DONE <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (EN && !trig_r) begin
            state_q    <= StRun;
            mode_q     <= mode_sel;
            count_q    <= '0;
            beat_q     <= '0;
            for (int i = 0; i < LANES; i++) begin
              lfsr_q[i] <= step_state[i];
              prbs_q[i] <= step_data[i];
            end
            DATA       <= pat;
            DATA_VALID <= 1'b1;
            WRAP       <= wrap_hit;
          end else begin
            DATA       <= '0;
            DATA_VALID <= 1'b0;
          end
        end
        StRun: begin
          if (accept) begin
            count_q <= count_sel;
            beat_q  <= beat_q + 32'd1;
            for (int i = 0; i < LANES; i++) begin
              lfsr_q[i] <= step_state[i];
              prbs_q[i] <= step_data[i];
            end
          end
          if (!EN) begin
            state_q    <= StIdle;
            DATA       <= '0;
            DATA_VALID <= 1'b0;
          end else if (burst_end) begin
            state_q    <= StDone;
            DATA       <= '0;
            DATA_VALID <= 1'b0;
            BURST_DONE <= 1'b1;
          end else if (trig_r) begin
            state_q    <= StBlank;
            DATA       <= '0;
            DATA_VALID <= 1'b1;
          end else begin
            DATA       <= pat;
            DATA_VALID <= 1'b1;
            WRAP       <= wrap_hit;
          end
        end
        StBlank: begin
          if (!EN) begin
            state_q    <= StIdle;
            DATA       <= '0;
            DATA_VALID <= 1'b0;
          end else if (!trig_r) begin
            state_q    <= StRun;
            DATA       <= pat;
            DATA_VALID <= 1'b1;
            WRAP       <= wrap_hit;
          end else begin
            DATA       <= '0;
            DATA_VALID <= 1'b1;
          end
        end
        StDone: begin
          DATA       <= '0;
          DATA_VALID <= 1'b0;
          if (!EN) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jesd_pattern_gen.sv
// Directed bench: three generator configurations (wide continuous, narrow 4-bit counter,
// 8-beat burst) share clock, reset, TRIG, MODE and READY; each has its own EN.
module tb_jesd_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [1:0]  mode;
  logic        ready;
  logic        en_a, en_n, en_b;

  logic [63:0] data_a, data_b;
  logic [7:0]  data_n;
  logic        valid_a, wrap_a, done_a;
  logic        valid_n, wrap_n, done_n;
  logic        valid_b, wrap_b, done_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jesd_pattern_gen u_dut_a (
    .CLK(clk), .RST(rst), .EN(en_a), .TRIG(trig), .MODE(mode), .READY(ready),
    .DATA(data_a), .DATA_VALID(valid_a), .WRAP(wrap_a), .BURST_DONE(done_a)
  );

  jesd_pattern_gen #(
    .LANES(1), .DATA_W(8), .MARK_W(4), .MARKER(4'b1010), .CNT_W(4), .BURST_LEN(0)
  ) u_dut_n (
    .CLK(clk), .RST(rst), .EN(en_n), .TRIG(trig), .MODE(mode), .READY(ready),
    .DATA(data_n), .DATA_VALID(valid_n), .WRAP(wrap_n), .BURST_DONE(done_n)
  );

  jesd_pattern_gen #(
    .BURST_LEN(8)
  ) u_dut_b (
    .CLK(clk), .RST(rst), .EN(en_b), .TRIG(trig), .MODE(mode), .READY(ready),
    .DATA(data_b), .DATA_VALID(valid_b), .WRAP(wrap_b), .BURST_DONE(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_beats;
    int n_done;

    rst = 1'b1; trig = 1'b0; mode = 2'd0; ready = 1'b1;
    en_a = 1'b0; en_n = 1'b0; en_b = 1'b0;
    tick();
    tick();
    check("rst_data_a", data_a, 64'h0);
    check("rst_valid_a", 64'(valid_a), 64'h0);
    check("rst_wrap_a", 64'(wrap_a), 64'h0);
    check("rst_done_b", 64'(done_b), 64'h0);

    // COUNT mode on two lanes.
    rst = 1'b0; en_a = 1'b1;
    tick();
    check("cnt_beat0", data_a, 64'h0000001A_0000000A);
    check("cnt_valid0", 64'(valid_a), 64'h1);
    check("cnt_wrap0", 64'(wrap_a), 64'h0);
    tick();
    check("cnt_beat1", data_a, 64'h0000002A_0000001A);
    tick(); tick(); tick(); tick();
    check("cnt_beat5", data_a, 64'h0000006A_0000005A);

    // TRIG blanking: beat 6 is still accepted while trig_r rises, blank two edges later.
    trig = 1'b1;
    tick();
    check("trig_edge1", data_a, 64'h0000007A_0000006A);
    tick();
    check("blank_data", data_a, 64'h0);
    check("blank_valid", 64'(valid_a), 64'h1);
    tick();
    trig = 1'b0;
    tick();
    check("blank_hold", data_a, 64'h0);
    tick();
    check("resume_cnt7", data_a, 64'h0000008A_0000007A);

    // READY back-pressure holds count 9.
    tick(); tick();
    check("pre_ready_cnt9", data_a, 64'h000000AA_0000009A);
    ready = 1'b0;
    tick();
    check("ready_hold1", data_a, 64'h000000AA_0000009A);
    tick(); tick(); tick();
    check("ready_hold4", data_a, 64'h000000AA_0000009A);
    ready = 1'b1;
    tick();
    check("ready_cnt10", data_a, 64'h000000BA_000000AA);

    en_a = 1'b0;
    tick();
    check("idle_data", data_a, 64'h0);
    check("idle_valid", 64'(valid_a), 64'h0);

    // WALK1, with a MODE change mid-run that must be ignored.
    mode = 2'd3; en_a = 1'b1;
    tick();
    check("walk_cnt0", data_a, 64'h00000001_00000001);
    mode = 2'd2;
    tick(); tick();
    check("walk_cnt2", data_a, 64'h00000004_00000004);
    en_a = 1'b0;
    tick();
    en_a = 1'b1;
    tick();
    check("const_lanes", data_a, 64'hA1A1A1A1_A0A0A0A0);
    en_a = 1'b0;
    mode = 2'd0;
    tick();

    // Narrow 4-bit counter wrap.
    en_n = 1'b1;
    tick();
    check("narrow_beat1", 64'(data_n), 64'h0A);
    for (int k = 1; k < 15; k++) tick();
    check("narrow_beat15", 64'(data_n), 64'hEA);
    check("narrow_wrap15", 64'(wrap_n), 64'h0);
    tick();
    check("narrow_beat16", 64'(data_n), 64'hFA);
    check("narrow_wrap16", 64'(wrap_n), 64'h1);
    tick();
    check("narrow_beat17", 64'(data_n), 64'h0A);
    check("narrow_wrap17", 64'(wrap_n), 64'h0);
    check("narrow_nodone", 64'(done_n), 64'h0);
    en_n = 1'b0;
    tick();

    // PRBS15 burst of 8.
    mode = 2'd1; en_b = 1'b1;
    tick();
    check("prbs_first", data_b, 64'h00040018_0002000C);
    check("prbs_nowrap", 64'(wrap_b), 64'h0);
    n_beats = 1;
    n_done = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (valid_b) n_beats++;
      if (done_b) n_done++;
    end
    check("burst_beats", 64'(n_beats), 64'd8);
    check("burst_done_cnt", 64'(n_done), 64'd1);
    check("burst_valid_low", 64'(valid_b), 64'h0);
    check("burst_data_low", data_b, 64'h0);

    // Restart needs EN toggle, then reset mid-burst at beat 3.
    en_b = 1'b0;
    tick();
    en_b = 1'b1;
    tick();
    check("restart_first", data_b, 64'h00040018_0002000C);
    tick(); tick();
    check("beat3_valid", 64'(valid_b), 64'h1);
    rst = 1'b1;
    tick();
    check("rst_mid_data", data_b, 64'h0);
    check("rst_mid_valid", 64'(valid_b), 64'h0);
    check("rst_mid_done", 64'(done_b), 64'h0);
    rst = 1'b0;
    tick();
    check("rst_restart", data_b, 64'h00040018_0002000C);
    check("rst_restart_v", 64'(valid_b), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
